// File: rtl/cbb_pulse_throttle_if.sv
// Event-side bundle of the pulse throttle. The producer drives i_pulse and i_clr;
// the throttle drives the paced pulse and the status outputs.
// P_CNT_W must match the P_CNT_W of the throttle instance it connects to.
interface cbb_pulse_throttle_if #(
    parameter int P_CNT_W = 4
);
    logic               i_pulse;
    logic               i_clr;
    logic               o_pulse;
    logic [P_CNT_W-1:0] o_pending;
    logic               o_busy;
    logic               o_overflow;

    modport slave (
        input  i_pulse,
        input  i_clr,
        output o_pulse,
        output o_pending,
        output o_busy,
        output o_overflow
    );

    modport master (
        output i_pulse,
        output i_clr,
        input  o_pulse,
        input  o_pending,
        input  o_busy,
        input  o_overflow
    );
endinterface

// File: rtl/cbb_pulse_throttle.sv
// Pulse throttle for the source side of a pulse synchronizer.
// Bursty single-cycle events are counted and re-emitted as registered single-cycle
// pulses. Consecutive output pulses are at least P_GAP_CYCLES clocks apart, so the
// downstream stretcher/synchronizer never merges two events.
// When the block is idle and nothing is pending, an incoming event bypasses the
// counter and fires on the very next edge.
module cbb_pulse_throttle #(
    parameter int P_GAP_CYCLES = 6,
    parameter int P_CNT_W      = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    cbb_pulse_throttle_if.slave   io
);

    localparam int LP_TMR_W = $clog2(P_GAP_CYCLES);
    localparam logic [LP_TMR_W-1:0] LP_TMR_LOAD = LP_TMR_W'(P_GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FIRE = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [LP_TMR_W-1:0]  r_timer;
    logic [LP_TMR_W-1:0]  w_timer_next;
    logic [P_CNT_W-1:0]   r_pending;
    logic [P_CNT_W-1:0]   w_pending_next;
    logic                 r_pulse;
    logic                 w_pulse_next;
    logic                 r_overflow;
    logic                 w_overflow_next;

    logic                 w_pend_zero;
    logic                 w_pend_full;
    logic                 w_fire_ok;
    logic                 w_want;
    logic                 w_fire;
    logic                 w_inc;
    logic                 w_dec;

    // Fire decision, backlog accounting, gap timer and next-state logic.
    always_comb begin
        w_state_next    = r_state;
        w_timer_next    = r_timer;
        w_pending_next  = r_pending;
        w_overflow_next = r_overflow;
        w_pulse_next    = 1'b0;

        w_pend_zero = (r_pending == '0);
        w_pend_full = &r_pending;
        w_fire_ok   = (r_state == S_IDLE) || ((r_state == S_GAP) && (r_timer == '0));
        w_want      = !w_pend_zero || io.i_pulse;
        // A clear suppresses firing on its own edge.
        w_fire      = w_fire_ok && w_want && !io.i_clr;
        // An event that fires straight from an empty backlog is never counted.
        w_inc       = io.i_pulse && !(w_fire && w_pend_zero);
        w_dec       = w_fire && !w_pend_zero;

        w_pulse_next = w_fire;

        // The timer runs through FIRE and GAP and rests at zero.
        if (w_fire) begin
            w_timer_next = LP_TMR_LOAD;
        end else if ((r_state != S_IDLE) && (r_timer != '0)) begin
            w_timer_next = r_timer - 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                if (w_fire) begin
                    w_state_next = S_FIRE;
                end
            end
            S_FIRE: begin
                w_state_next = S_GAP;
            end
            S_GAP: begin
                if (w_fire) begin
                    w_state_next = S_FIRE;
                end else if ((r_timer == '0) && !w_want) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // Clear wins over counting and also discards a same-cycle event; the gap
        // timer and state are left to run their course.
        if (io.i_clr) begin
            w_pending_next  = '0;
            w_overflow_next = 1'b0;
        end else if (w_inc && !w_dec) begin
            if (w_pend_full) begin
                w_overflow_next = 1'b1;
            end else begin
                w_pending_next = r_pending + 1'b1;
            end
        end else if (w_dec && !w_inc) begin
            w_pending_next = r_pending - 1'b1;
        end
    end

    // State, timer, backlog and output registers; reset drops everything at once.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_timer    <= '0;
            r_pending  <= '0;
            r_pulse    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_timer    <= w_timer_next;
            r_pending  <= w_pending_next;
            r_pulse    <= w_pulse_next;
            r_overflow <= w_overflow_next;
        end
    end

    assign io.o_pulse    = r_pulse;
    assign io.o_pending  = r_pending;
    assign io.o_overflow = r_overflow;
    assign io.o_busy     = (r_state != S_IDLE) || (r_pending != '0);

endmodule
